// File: rtl/ifu_fetch_pkg.sv
// -----------------------------------------------------------------------------
// ifu_fetch_pkg
//   Shared widths, constants and types for the instruction fetch unit.
//   REG_WIDTH / INST_WIDTH / PC_RST mirror the core-wide width definitions;
//   INST_NOP is the canonical NOP encoding (addi x0, x0, 0).
// -----------------------------------------------------------------------------
package ifu_fetch_pkg;

    localparam int REG_WIDTH  = 64;
    localparam int INST_WIDTH = 32;

    localparam logic [REG_WIDTH-1:0]  PC_RST   = 64'h0000_0000_8000_0000;
    localparam logic [REG_WIDTH-1:0]  PC_STEP  = 64'd4;
    localparam logic [INST_WIDTH-1:0] INST_NOP = 32'h0000_0013;

    // One buffered instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [REG_WIDTH-1:0]  pc;
        logic [INST_WIDTH-1:0] inst;
    } fetch_entry_t;

    // Force a PC onto a word boundary by clearing the two low bits.
    function automatic logic [REG_WIDTH-1:0] word_align(input logic [REG_WIDTH-1:0] pc);
        return {pc[REG_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   DEPTH-entry circular buffer of {pc, inst} pairs between the instruction
//   memory response and decode. Power-of-two DEPTH (2, 4 or 8) lets the
//   pointers wrap naturally.
//
// Ports
//   clk, rst    clock, asynchronous active-high reset
//   enq         write enq_data at the tail
//   enq_data    entry to write
//   deq         pop the head (ignored when empty)
//   flush       discard every entry; wins over enq and deq
//   head        entry at the head (undefined content when count == 0)
//   count       number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo
    import ifu_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq,
    input  fetch_entry_t             enq_data,
    input  logic                     deq,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t       mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_enq;
    logic               do_deq;

    // A pop frees a slot in the same cycle, so enqueue into a full buffer is
    // legal when it coincides with a dequeue.
    assign do_deq = deq && (count != '0) && !flush;
    assign do_enq = enq && !flush && ((count != CNT_W'(DEPTH)) || do_deq);

    assign head = mem[rd_ptr];

    // NOTE: the storage array has no reset; occupancy is tracked by count and
    //       the pointers, so stale contents are never observed downstream.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            mem[wr_ptr] <= enq_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_enq, do_deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// -----------------------------------------------------------------------------
// ifu_fetch
//   Instruction fetch unit. Owns the fetch PC, issues one word-aligned request
//   per cycle to a fixed-latency-1, never-stalling instruction memory, and
//   buffers responses in fetch_fifo for decode. Requests are only issued when
//   the buffer is guaranteed to have room for the response. Redirects from
//   later stages reload the PC, flush the buffer and flip the epoch so any
//   wrong-path response is discarded.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   redirect_valid   redirect request (branch/jump/trap), highest priority
//   redirect_pc      redirect target; low two bits are ignored
//   imem_req         fetch request issued this cycle
//   imem_addr        fetch address (current fetch PC, word aligned)
//   imem_rsp_valid   response for the request issued last cycle
//   imem_rsp_inst    returned instruction word
//   out_valid        instruction presented to decode
//   out_ready        decode accepts this cycle
//   out_pc           PC of the presented instruction (0 when empty)
//   out_inst         presented instruction (0 when empty)
// -----------------------------------------------------------------------------
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [REG_WIDTH-1:0] RST_PC = PC_RST,
    parameter int                   DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    redirect_valid,
    input  logic [REG_WIDTH-1:0]    redirect_pc,
    output logic                    imem_req,
    output logic [REG_WIDTH-1:0]    imem_addr,
    input  logic                    imem_rsp_valid,
    input  logic [INST_WIDTH-1:0]   imem_rsp_inst,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [REG_WIDTH-1:0]    out_pc,
    output logic [INST_WIDTH-1:0]   out_inst
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    logic [REG_WIDTH-1:0]   fetch_pc;
    logic                   epoch;
    logic                   inflight;
    logic [REG_WIDTH-1:0]   inflight_pc;
    logic                   inflight_epoch;

    logic [CNT_W-1:0]       count;
    fetch_entry_t           head;
    fetch_entry_t           rsp_entry;
    logic                   deq;
    logic                   rsp_accept;
    logic [OCC_W-1:0]       occupancy;

    assign out_valid = (count != '0);
    assign deq       = out_valid && out_ready;
    assign imem_addr = fetch_pc;

    // Outputs read zero while empty so nothing from the unreset storage leaks.
    assign out_pc    = out_valid ? head.pc   : '0;
    assign out_inst  = out_valid ? head.inst : '0;

    assign rsp_entry = '{pc: inflight_pc, inst: imem_rsp_inst};

    // Issue and accept decisions. Occupancy counts the slot the in-flight
    // response will need next cycle, minus the slot decode frees this cycle;
    // deq implies count >= 1 so the subtraction cannot underflow.
    // NOTE: every always_comb output gets a default first so no path can
    //       leave it unassigned and infer a latch.
    always_comb begin
        occupancy  = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(deq);
        imem_req   = 1'b0;
        rsp_accept = 1'b0;
        if (!rst && !redirect_valid) begin
            imem_req = (occupancy < OCC_W'(DEPTH));
            // A response is kept only if a request is really outstanding and
            // it was issued in the current epoch (not down a redirected path).
            rsp_accept = imem_rsp_valid && inflight && (inflight_epoch == epoch);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    //       samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc       <= RST_PC;
            epoch          <= 1'b0;
            inflight       <= 1'b0;
            inflight_pc    <= '0;
            inflight_epoch <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= word_align(redirect_pc);
            epoch    <= ~epoch;
            inflight <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                inflight_pc    <= fetch_pc;
                inflight_epoch <= epoch;
                // Wraps silently from the top of the address space to zero.
                fetch_pc       <= fetch_pc + PC_STEP;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .enq      (rsp_accept),
        .enq_data (rsp_entry),
        .deq      (deq),
        .flush    (redirect_valid),
        .head     (head),
        .count    (count)
    );

endmodule
